chimera_clu_pwr_seq: RTL and testbench

- Per-cluster power-up/power-down sequencer sitting directly upstream of the cluster domain.
- Drives each external cluster's isolation request, cluster reset and cluster clock enable.
- Consumes the per-cluster "isolated" status returned by the domain's AXI isolation stage.
- Guarantees a cluster is never reset or clock-gated while AXI traffic can still cross its boundary, and is never de-isolated before its reset has been released and settled.

---
 rtl/chimera_clu_pwr_seq.sv | 192 +++++++++++++++++++
 tb/tb_chimera_clu_pwr_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chimera_clu_pwr_seq.sv
// Per-cluster power sequencer: isolation, reset and clock-enable ordering for each cluster domain.
// Optional wait timeouts in DEISO/ISO with a sticky error flag: define CHIMERA_CLU_PWR_SEQ_TIMEOUT_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_OFF     | cluster off: isolated, in reset, clock gated
// S_CLK_ON  | clock running with reset held for ResetCycles
// S_RST_REL | reset released, settling for SettleCycles
// S_DEISO   | isolation dropped, waiting for isolated_i to fall
// S_ON      | cluster fully up
// S_ISO     | isolation requested, waiting for isolated_i to rise
// S_RST_ON  | reset asserted with clock running for ResetCycles
module chimera_clu_pwr_seq #(
    parameter int unsigned NumClusters   = 2,
    parameter int unsigned ResetCycles   = 8,
    parameter int unsigned SettleCycles  = 4,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                   soc_clk_i,
    input  logic                   rst_ni,
    input  logic [NumClusters-1:0] clu_en_i,
    input  logic [NumClusters-1:0] isolated_i,
    input  logic [NumClusters-1:0] err_clr_i,
    output logic [NumClusters-1:0] isolate_o,
    output logic [NumClusters-1:0] clu_rst_no,
    output logic [NumClusters-1:0] clu_clk_en_o,
    output logic [NumClusters-1:0] on_o,
    output logic [NumClusters-1:0] busy_o,
    output logic [NumClusters-1:0] err_o
);

    localparam int unsigned MaxRs     = (ResetCycles > SettleCycles) ? ResetCycles : SettleCycles;
    localparam int unsigned MaxCycles = (MaxRs > TimeoutCycles) ? MaxRs : TimeoutCycles;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    // Terminal counts: the counter is cleared on state entry, so N cycles end at N-1.
    localparam logic [CntW-1:0] RstTc = CntW'(ResetCycles - 1);
    localparam logic [CntW-1:0] SetTc = CntW'(SettleCycles - 1);
`ifdef CHIMERA_CLU_PWR_SEQ_TIMEOUT_EN
    localparam logic [CntW-1:0] ToTc  = CntW'(TimeoutCycles - 1);
`endif

    typedef enum logic [2:0] {
        S_OFF,
        S_CLK_ON,
        S_RST_REL,
        S_DEISO,
        S_ON,
        S_ISO,
        S_RST_ON
    } state_e;

    // {isolate, rst_n, clk_en, on, busy}
    function automatic logic [4:0] dec(input state_e s);
        case (s)
            S_OFF:     return 5'b10000;
            S_CLK_ON:  return 5'b10101;
            S_RST_REL: return 5'b11101;
            S_DEISO:   return 5'b01101;
            S_ON:      return 5'b01110;
            S_ISO:     return 5'b11101;
            S_RST_ON:  return 5'b10101;
            default:   return 5'b10000;
        endcase
    endfunction

`ifndef CHIMERA_CLU_PWR_SEQ_TIMEOUT_EN
    logic w_unused_err_clr;
    assign w_unused_err_clr = ^err_clr_i;
`endif

    for (genvar g = 0; g < NumClusters; g++) begin : g_clu
        state_e          r_state;
        logic [CntW-1:0] r_cnt;
        logic [4:0]      r_out;
        logic [CntW-1:0] w_cnt_inc;

        assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

`ifdef CHIMERA_CLU_PWR_SEQ_TIMEOUT_EN
        logic r_err;
        assign err_o[g] = r_err;
`else
        assign err_o[g] = 1'b0;
`endif

        always_ff @(posedge soc_clk_i) begin
            if (!rst_ni) begin
                r_state <= S_OFF;
                r_cnt   <= '0;
                r_out   <= dec(S_OFF);
`ifdef CHIMERA_CLU_PWR_SEQ_TIMEOUT_EN
                r_err   <= 1'b0;
`endif
            end else begin
`ifdef CHIMERA_CLU_PWR_SEQ_TIMEOUT_EN
                // A timeout below overrides this clear in the same cycle.
                if (err_clr_i[g]) r_err <= 1'b0;
`endif
                case (r_state)
                    S_OFF: begin
                        if (clu_en_i[g]) begin
                            r_state <= S_CLK_ON;
                            r_out   <= dec(S_CLK_ON);
                            r_cnt   <= '0;
                        end
                    end
                    S_CLK_ON: begin
                        if (r_cnt == RstTc) begin
                            r_state <= S_RST_REL;
                            r_out   <= dec(S_RST_REL);
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_RST_REL: begin
                        if (r_cnt == SetTc) begin
                            r_state <= S_DEISO;
                            r_out   <= dec(S_DEISO);
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_DEISO: begin
                        if (!isolated_i[g]) begin
                            r_state <= S_ON;
                            r_out   <= dec(S_ON);
                            r_cnt   <= '0;
                        end
`ifdef CHIMERA_CLU_PWR_SEQ_TIMEOUT_EN
                        else if (r_cnt == ToTc) begin
                            r_err   <= 1'b1;
                            r_state <= S_ISO;
                            r_out   <= dec(S_ISO);
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
`endif
                    end
                    S_ON: begin
                        if (!clu_en_i[g]) begin
                            r_state <= S_ISO;
                            r_out   <= dec(S_ISO);
                            r_cnt   <= '0;
                        end
                    end
                    S_ISO: begin
                        if (isolated_i[g]) begin
                            r_state <= S_RST_ON;
                            r_out   <= dec(S_RST_ON);
                            r_cnt   <= '0;
                        end
`ifdef CHIMERA_CLU_PWR_SEQ_TIMEOUT_EN
                        else if (r_cnt == ToTc) begin
                            r_err   <= 1'b1;
                            r_state <= S_RST_ON;
                            r_out   <= dec(S_RST_ON);
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
`endif
                    end
                    S_RST_ON: begin
                        if (r_cnt == RstTc) begin
                            r_state <= S_OFF;
                            r_out   <= dec(S_OFF);
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state <= S_OFF;
                        r_out   <= dec(S_OFF);
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign isolate_o[g]    = r_out[4];
        assign clu_rst_no[g]   = r_out[3];
        assign clu_clk_en_o[g] = r_out[2];
        assign on_o[g]         = r_out[1];
        assign busy_o[g]       = r_out[0];
    end

endmodule

// File: tb/tb_chimera_clu_pwr_seq.sv
// Bench for chimera_clu_pwr_seq: per-cycle expected outputs from a reference model go through a
// scoreboard queue; a small domain model answers isolate_o with a delayed isolated_i.
module tb_chimera_clu_pwr_seq;
    localparam int N  = 2;
    localparam int RC = 8;
    localparam int SC = 4;
    localparam int TC = 16;

    localparam int OFF = 0, CLK_ON = 1, RST_REL = 2, DEISO = 3, ON = 4, ISO = 5, RST_ON = 6;

`ifdef CHIMERA_CLU_PWR_SEQ_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic         soc_clk_i = 1'b0;
    logic         rst_ni;
    logic [N-1:0] clu_en_i, isolated_i, err_clr_i;
    logic [N-1:0] isolate_o, clu_rst_no, clu_clk_en_o, on_o, busy_o, err_o;

    chimera_clu_pwr_seq #(
        .NumClusters  (N),
        .ResetCycles  (RC),
        .SettleCycles (SC),
        .TimeoutCycles(TC)
    ) dut (
        .soc_clk_i   (soc_clk_i),
        .rst_ni      (rst_ni),
        .clu_en_i    (clu_en_i),
        .isolated_i  (isolated_i),
        .err_clr_i   (err_clr_i),
        .isolate_o   (isolate_o),
        .clu_rst_no  (clu_rst_no),
        .clu_clk_en_o(clu_clk_en_o),
        .on_o        (on_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 soc_clk_i = ~soc_clk_i;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int m_st[N];
    int m_left[N];
    bit m_err[N];
    logic [2*6-1:0] sb_q[$];

    int dom_dly_dn = 2;
    int dom_dly_up = 5;
    int dom_cnt[N];
    bit stuck_hi[N];
    bit stuck_lo[N];

    bit trk = 0;
    int first_clken = -1, first_rstn = -1, first_isodn = -1, first_on = -1;
    int busy_n = 0, busy_last = -1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, expv, cyc);
        end
    endtask

    // {isolate, rst_n, clk_en, on, busy, err}
    function automatic logic [5:0] exp_vec(input int st, input bit err);
        case (st)
            OFF:     return {5'b10000, err};
            CLK_ON:  return {5'b10101, err};
            RST_REL: return {5'b11101, err};
            DEISO:   return {5'b01101, err};
            ON:      return {5'b01110, err};
            ISO:     return {5'b11101, err};
            RST_ON:  return {5'b10101, err};
            default: return 6'h3f;
        endcase
    endfunction

    task automatic model_edge();
        logic [2*6-1:0] v;
        bit set_err;
        v = '0;
        for (int i = 0; i < N; i++) begin
            set_err = 1'b0;
            if (!rst_ni) begin
                m_st[i] = OFF; m_left[i] = 0; m_err[i] = 1'b0;
            end else begin
                case (m_st[i])
                    OFF: begin
                        if (clu_en_i[i]) begin m_st[i] = CLK_ON; m_left[i] = RC; end
                    end
                    CLK_ON: begin
                        m_left[i]--;
                        if (m_left[i] == 0) begin m_st[i] = RST_REL; m_left[i] = SC; end
                    end
                    RST_REL: begin
                        m_left[i]--;
                        if (m_left[i] == 0) begin m_st[i] = DEISO; m_left[i] = TC; end
                    end
                    DEISO: begin
                        if (!isolated_i[i]) m_st[i] = ON;
                        else if (TO_EN) begin
                            m_left[i]--;
                            if (m_left[i] == 0) begin set_err = 1'b1; m_st[i] = ISO; m_left[i] = TC; end
                        end
                    end
                    ON: begin
                        if (!clu_en_i[i]) begin m_st[i] = ISO; m_left[i] = TC; end
                    end
                    ISO: begin
                        if (isolated_i[i]) begin m_st[i] = RST_ON; m_left[i] = RC; end
                        else if (TO_EN) begin
                            m_left[i]--;
                            if (m_left[i] == 0) begin set_err = 1'b1; m_st[i] = RST_ON; m_left[i] = RC; end
                        end
                    end
                    RST_ON: begin
                        m_left[i]--;
                        if (m_left[i] == 0) m_st[i] = OFF;
                    end
                    default: m_st[i] = OFF;
                endcase
                if (set_err) m_err[i] = 1'b1;
                else if (TO_EN && err_clr_i[i]) m_err[i] = 1'b0;
            end
            v[i*6 +: 6] = exp_vec(m_st[i], m_err[i]);
        end
        sb_q.push_back(v);
    endtask

    task automatic step();
        logic [2*6-1:0] e_vec;
        logic [5:0] act;
        int dly;
        model_edge();
        @(posedge soc_clk_i);
        cyc++;
        #1;
        e_vec = sb_q.pop_front();
        for (int i = 0; i < N; i++) begin
            act = {isolate_o[i], clu_rst_no[i], clu_clk_en_o[i], on_o[i], busy_o[i], err_o[i]};
            chk($sformatf("clu%0d_outputs", i), 32'(act), 32'(e_vec[i*6 +: 6]));
        end
        if (trk) begin
            if (clu_clk_en_o[0] && first_clken < 0) first_clken = cyc;
            if (clu_rst_no[0] && first_rstn < 0) first_rstn = cyc;
            if (!isolate_o[0] && first_isodn < 0) first_isodn = cyc;
            if (on_o[0] && first_on < 0) first_on = cyc;
            if (busy_o[0]) begin busy_n++; busy_last = cyc; end
        end
        for (int i = 0; i < N; i++) begin
            if (stuck_hi[i]) isolated_i[i] = 1'b1;
            else if (stuck_lo[i]) isolated_i[i] = 1'b0;
            else if (isolate_o[i] != isolated_i[i]) begin
                dly = isolate_o[i] ? dom_dly_up : dom_dly_dn;
                if (dom_cnt[i] >= dly) begin
                    isolated_i[i] = isolate_o[i];
                    dom_cnt[i] = 0;
                end else dom_cnt[i]++;
            end else dom_cnt[i] = 0;
        end
    endtask

    initial begin
        bit ok;
        rst_ni = 1'b0; clu_en_i = '0; err_clr_i = '0; isolated_i = '1;
        for (int i = 0; i < N; i++) begin
            m_st[i] = OFF; m_left[i] = 0; m_err[i] = 1'b0;
            dom_cnt[i] = 0; stuck_hi[i] = 1'b0; stuck_lo[i] = 1'b0;
        end

        repeat (3) step();
        rst_ni = 1'b1;
        chk("rst_isolate", 32'(isolate_o), 32'h3);
        chk("rst_clu_rst_n", 32'(clu_rst_no), 32'h0);
        chk("rst_clk_en", 32'(clu_clk_en_o), 32'h0);
        chk("rst_busy_on_err", 32'({busy_o, on_o, err_o}), 32'h0);

        // Power-up timeline of cluster 0
        while (cyc < 10) step();
        trk = 1'b1;
        clu_en_i[0] = 1'b1;
        repeat (20) step();
        trk = 1'b0;
        chk("up_clk_en_edge", 32'(first_clken), 32'd11);
        chk("up_rst_rel_edge", 32'(first_rstn), 32'd19);
        chk("up_deiso_edge", 32'(first_isodn), 32'd23);
        chk("up_on_edge", 32'(first_on), 32'd26);
        chk("up_busy_cycles", 32'(busy_n), 32'd15);
        chk("up_busy_last", 32'(busy_last), 32'd25);

        // Power-down from ON
        clu_en_i[0] = 1'b0;
        repeat (25) step();
        chk("dn_final_off", 32'({clu_clk_en_o[0], busy_o[0], isolate_o[0]}), 32'h1);

        // Short request pulse: full up then immediate down
        clu_en_i[0] = 1'b1;
        repeat (3) step();
        clu_en_i[0] = 1'b0;
        repeat (60) step();
        chk("pulse_final_off", 32'({on_o[0], busy_o[0]}), 32'h0);

        // Independence: cluster 0 up while cluster 1 down in the same cycles
        clu_en_i[1] = 1'b1;
        repeat (30) step();
        clu_en_i = 2'b01;
        repeat (40) step();
        chk("indep_on", 32'(on_o), 32'h1);
        clu_en_i = 2'b10;
        repeat (35) step();
        chk("indep_swap_on", 32'(on_o), 32'h2);

        // Reset in the middle of cluster 0 RST_REL
        clu_en_i = 2'b01;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (clu_rst_no[0] && isolate_o[0] && busy_o[0]) begin ok = 1'b1; break; end
        end
        chk("wait_rst_rel", 32'(ok), 32'h1);
        rst_ni = 1'b0; clu_en_i = '0;
        step();
        rst_ni = 1'b1;
        chk("midrst_isolate", 32'(isolate_o), 32'h3);
        chk("midrst_rst_n", 32'(clu_rst_no), 32'h0);
        chk("midrst_clk_en", 32'(clu_clk_en_o), 32'h0);
        chk("midrst_busy", 32'(busy_o), 32'h0);
        repeat (10) step();

        // DEISO wait with isolated_i stuck high, error clear held (set wins)
        stuck_hi[0] = 1'b1; err_clr_i[0] = 1'b1; clu_en_i[0] = 1'b1;
        repeat (40) step();
        clu_en_i[0] = 1'b0; err_clr_i[0] = 1'b0; stuck_hi[0] = 1'b0;
        repeat (60) step();

        // ISO wait with isolated_i stuck low
        clu_en_i[0] = 1'b1;
        repeat (20) step();
        stuck_lo[0] = 1'b1; clu_en_i[0] = 1'b0;
        repeat (30) step();
        chk("iso_err_sticky", 32'(err_o[0]), 32'(TO_EN));
        chk("iso_rst_n", 32'(clu_rst_no[0]), 32'(!TO_EN));
        err_clr_i[0] = 1'b1;
        step();
        err_clr_i[0] = 1'b0;
        step();
        chk("err_cleared", 32'(err_o[0]), 32'h0);
        stuck_lo[0] = 1'b0;
        repeat (25) step();
        chk("final_off", 32'({busy_o, on_o, clu_clk_en_o}), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
